// File: rtl/range_info_pipe_pkg.sv
// Shared definitions for the range-info pipeline: collision-mode encodings
// and the width helpers used to size the position/shift fields.
package range_info_pipe_pkg;

   localparam int MODE_OR_MERGE = 0;
   localparam int MODE_PRIORITY = 1;

   // Index of the highest set bit (0 for values below 2).
   function automatic int msb_of(input int value);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++) begin
         if (value >= (1 << b)) r = b;
      end
      return r;
   endfunction

   function automatic int clamp_pos(input int field, input int idx);
      return (field < idx) ? idx : field;
   endfunction

endpackage

// File: rtl/range_info_pipe_pos_select.sv
// Per-position select: finds the ranges that landed on POSITION, reduces their
// shifts by priority or OR-merge, and flags a collision on two or more hits.
module range_pos_select
   import range_info_pipe_pkg::*;
#(
   parameter int RANGES_MAX     = 8,
   parameter int RANGE_INFO_MSB = 3,
   parameter int COLLISION_MODE = MODE_PRIORITY,
   parameter int POSITION       = 0
) (
   input  logic [RANGES_MAX-1:0]                rvalid,
   input  logic [RANGES_MAX*RANGE_INFO_MSB-1:0] pos,
   output logic                                 hit,
   output logic [RANGE_INFO_MSB-1:0]            shift,
   output logic                                 collision
);

   localparam int FW = RANGE_INFO_MSB;

   always_comb begin
      hit       = 1'b0;
      shift     = '0;
      collision = 1'b0;
      for (int j = 0; j < RANGES_MAX; j++) begin
         if (rvalid[j] && int'(pos[j*FW +: FW]) == POSITION) begin
            if (hit) collision = 1'b1;
            if (COLLISION_MODE == MODE_OR_MERGE)
               shift = shift | (pos[j*FW +: FW] - FW'(j));
            else if (!hit)
               shift = pos[j*FW +: FW] - FW'(j);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/range_info_pipe.sv
// Two-stage handshaked range-info decoder: stage 1 clamps and validates each
// range position, stage 2 builds the per-position mask/shift into the output slot.
module range_info_pipe
   import range_info_pipe_pkg::*;
#(
   parameter int WORD_MAX_LEN   = 8,
   parameter int RANGES_MAX     = 8,
   parameter int RANGE_INFO_MSB = 1 + msb_of(WORD_MAX_LEN - 1),
   parameter int COLLISION_MODE = MODE_PRIORITY,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                     CLK,
   input  logic                                     reset,
   input  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0] in_range_info,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic [WORD_MAX_LEN-1:0]                  out_if_range,
   output logic [WORD_MAX_LEN*RANGE_INFO_MSB-1:0]   out_shift_val,
   output logic                                     out_collision,
   output logic                                     out_overflow,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [CNT_WIDTH-1:0]                     collision_cnt,
   input  logic                                     cnt_clear
);

   localparam int FW = RANGE_INFO_MSB;
   localparam int DW = RANGE_INFO_MSB + 1;

   logic                       en;
   logic [RANGES_MAX-1:0]      dec_rvalid;
   logic [RANGES_MAX*FW-1:0]   dec_pos;
   logic                       dec_overflow;

   logic                       s1_valid;
   logic [RANGES_MAX-1:0]      s1_rvalid;
   logic [RANGES_MAX*FW-1:0]   s1_pos;
   logic                       s1_overflow;

   logic [WORD_MAX_LEN-1:0]    sel_hit;
   logic [WORD_MAX_LEN-1:0]    sel_coll;
   logic [WORD_MAX_LEN*FW-1:0] sel_shift;

   // Whole pipeline advances together; only the output slot can stall it.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // NOTE: every output of this block gets a default before the loop so no latch is inferred.
   always_comb begin
      dec_rvalid   = '0;
      dec_pos      = '0;
      dec_overflow = 1'b0;
      for (int i = 0; i < RANGES_MAX; i++) begin
         if (in_range_info[i*DW + FW]) begin
            if (clamp_pos(int'(in_range_info[i*DW +: FW]), i) < WORD_MAX_LEN) begin
               dec_rvalid[i]       = 1'b1;
               dec_pos[i*FW +: FW] = FW'(clamp_pos(int'(in_range_info[i*DW +: FW]), i));
            end else begin
               dec_overflow = 1'b1;
            end
         end
      end
   end

   for (genvar p = 0; p < WORD_MAX_LEN; p++) begin : g_pos
      range_pos_select #(
         .RANGES_MAX     (RANGES_MAX),
         .RANGE_INFO_MSB (RANGE_INFO_MSB),
         .COLLISION_MODE (COLLISION_MODE),
         .POSITION       (p)
      ) u_sel (
         .rvalid    (s1_rvalid),
         .pos       (s1_pos),
         .hit       (sel_hit[p]),
         .shift     (sel_shift[p*FW +: FW]),
         .collision (sel_coll[p])
      );
   end

   // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge CLK) begin
      if (reset) begin
         s1_valid      <= 1'b0;
         s1_rvalid     <= '0;
         s1_pos        <= '0;
         s1_overflow   <= 1'b0;
         out_valid     <= 1'b0;
         out_if_range  <= '0;
         out_shift_val <= '0;
         out_collision <= 1'b0;
         out_overflow  <= 1'b0;
      end else if (en) begin
         s1_valid      <= in_valid;
         s1_rvalid     <= dec_rvalid;
         s1_pos        <= dec_pos;
         s1_overflow   <= dec_overflow;
         out_valid     <= s1_valid;
         out_if_range  <= sel_hit;
         out_shift_val <= sel_shift;
         out_collision <= |sel_coll;
         out_overflow  <= s1_overflow;
      end
   end

   // Clear wins over a coincident increment.
   always_ff @(posedge CLK) begin
      if (reset || cnt_clear)
         collision_cnt <= '0;
      else if (out_valid && out_ready && out_collision && collision_cnt != '1)
         collision_cnt <= collision_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_range_info_pipe.sv
// Directed bench: a priority-mode instance and an OR-merge instance with a
// narrow counter share stimulus; expected values are hand-computed constants.
module tb_range_info_pipe;

   logic        CLK;
   logic        reset;
   logic [15:0] in_range_info;
   logic        in_valid;
   logic        out_ready;
   logic        cnt_clear;

   logic        in_ready_a, in_ready_b;
   logic [5:0]  out_if_range_a, out_if_range_b;
   logic [17:0] out_shift_val_a, out_shift_val_b;
   logic        out_collision_a, out_collision_b;
   logic        out_overflow_a, out_overflow_b;
   logic        out_valid_a, out_valid_b;
   logic [15:0] collision_cnt_a;
   logic [2:0]  collision_cnt_b;

   int checks   = 0;
   int failures = 0;

   range_info_pipe #(
      .WORD_MAX_LEN(6), .RANGES_MAX(4), .RANGE_INFO_MSB(3),
      .COLLISION_MODE(1), .CNT_WIDTH(16)
   ) dut_a (
      .CLK(CLK), .reset(reset), .in_range_info(in_range_info),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .out_if_range(out_if_range_a), .out_shift_val(out_shift_val_a),
      .out_collision(out_collision_a), .out_overflow(out_overflow_a),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .collision_cnt(collision_cnt_a), .cnt_clear(cnt_clear)
   );

   range_info_pipe #(
      .WORD_MAX_LEN(6), .RANGES_MAX(4), .RANGE_INFO_MSB(3),
      .COLLISION_MODE(0), .CNT_WIDTH(3)
   ) dut_b (
      .CLK(CLK), .reset(reset), .in_range_info(in_range_info),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .out_if_range(out_if_range_b), .out_shift_val(out_shift_val_b),
      .out_collision(out_collision_b), .out_overflow(out_overflow_b),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .collision_cnt(collision_cnt_b), .cnt_clear(cnt_clear)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One isolated word: checks two-edge latency, fields of both modes, counters after delivery.
   task automatic run_word(input string tag, input logic [15:0] w, input logic [5:0] e_if,
                           input logic [17:0] e_sh1, input logic [17:0] e_sh0,
                           input logic e_coll, input logic e_ovf,
                           input int e_cnt_a, input int e_cnt_b);
      @(negedge CLK);
      in_valid      = 1'b1;
      in_range_info = w;
      @(negedge CLK);
      in_valid      = 1'b0;
      in_range_info = '0;
      check({tag, "_early"}, out_valid_a, 0);
      @(negedge CLK);
      check({tag, "_valid"},  out_valid_a, 1);
      check({tag, "_valid_b"}, out_valid_b, 1);
      check({tag, "_if"},     out_if_range_a, e_if);
      check({tag, "_if_b"},   out_if_range_b, e_if);
      check({tag, "_shift"},  out_shift_val_a, e_sh1);
      check({tag, "_shift_b"}, out_shift_val_b, e_sh0);
      check({tag, "_coll"},   out_collision_a, e_coll);
      check({tag, "_coll_b"}, out_collision_b, e_coll);
      check({tag, "_ovf"},    out_overflow_a, e_ovf);
      check({tag, "_ovf_b"},  out_overflow_b, e_ovf);
      @(negedge CLK);
      check({tag, "_cnt"},   collision_cnt_a, e_cnt_a);
      check({tag, "_cnt_b"}, collision_cnt_b, e_cnt_b);
   endtask

   logic [15:0] bp_w  [4] = '{16'h00B8, 16'h00AA, 16'h9000, 16'hE80D};
   logic [5:0]  bp_if [4] = '{6'h09, 6'h04, 6'h08, 6'h24};
   logic [17:0] bp_sh [4] = '{18'h00400, 18'h00080, 18'h00000, 18'h28000};

   initial begin
      int got, sent, stall, emitted;
      reset         = 1'b1;
      in_valid      = 1'b0;
      in_range_info = '0;
      out_ready     = 1'b1;
      cnt_clear     = 1'b0;
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      check("rst_valid",    out_valid_a, 0);
      check("rst_if",       out_if_range_a, 0);
      check("rst_cnt",      collision_cnt_a, 0);
      check("rst_in_ready", in_ready_a, 1);

      // Ranges are {r3,r2,r1,r0}, 4 bits each: {active, pos[2:0]}.
      run_word("basic",   16'h00B8, 6'h09, 18'h00400, 18'h00400, 0, 0, 0, 0);
      run_word("coll",    16'h00AA, 6'h04, 18'h00080, 18'h000C0, 1, 0, 1, 1);
      run_word("clamp",   16'h9000, 6'h08, 18'h00000, 18'h00000, 0, 0, 1, 1);
      run_word("ovf",     16'h0F00, 6'h00, 18'h00000, 18'h00000, 0, 1, 1, 1);
      run_word("empty",   16'h0000, 6'h00, 18'h00000, 18'h00000, 0, 0, 1, 1);
      run_word("mixed",   16'hE80D, 6'h24, 18'h28000, 18'h28000, 0, 1, 1, 1);
      run_word("coll3",   16'h9BB0, 6'h08, 18'h00400, 18'h00600, 1, 0, 2, 2);

      // Backpressure: out_ready low for 5 cycles from the first out_valid.
      got = 0; sent = 0; stall = -1;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge CLK);
         in_valid      = (sent < 4);
         in_range_info = (sent < 4) ? bp_w[sent] : 16'h0000;
         if (out_valid_a && stall < 0) stall = 5;
         out_ready = !(stall > 0);
         #1;
         if (stall > 0) begin
            check("bp_in_ready", in_ready_a, 0);
            check("bp_held_cnt", sent, 2);
         end
         if (out_valid_a && got < 4) begin
            check("bp_if",    out_if_range_a, bp_if[got]);
            check("bp_shift", out_shift_val_a, bp_sh[got]);
            if (out_ready) got++;
         end
         if (in_valid && in_ready_a) sent++;
         if (stall > 0) stall--;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_all_out", got, 4);
      @(negedge CLK);
      check("bp_cnt", collision_cnt_a, 3);

      // Reset with two colliding words in flight.
      out_ready = 1'b0;
      @(negedge CLK);
      in_valid = 1'b1; in_range_info = 16'h00AA;
      @(negedge CLK);
      in_range_info = 16'h00AA;
      @(negedge CLK);
      in_valid = 1'b0; in_range_info = '0;
      check("inflight_valid", out_valid_a, 1);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      out_ready = 1'b1;
      check("mid_rst_valid", out_valid_a, 0);
      check("mid_rst_if",    out_if_range_a, 0);
      check("mid_rst_shift", out_shift_val_a, 0);
      check("mid_rst_coll",  out_collision_a, 0);
      check("mid_rst_ovf",   out_overflow_a, 0);
      check("mid_rst_cnt",   collision_cnt_a, 0);
      check("mid_rst_rdy_b", in_ready_b, 1);
      emitted = 0;
      repeat (5) begin
         @(negedge CLK);
         if (out_valid_a) emitted++;
      end
      check("mid_rst_none", emitted, 0);

      // Saturation: 9 colliding words; the 3-bit counter stops at 7.
      repeat (9) begin
         @(negedge CLK);
         in_valid = 1'b1; in_range_info = 16'h00AA;
      end
      @(negedge CLK);
      in_valid = 1'b0; in_range_info = '0;
      repeat (3) @(negedge CLK);
      check("sat_cnt",   collision_cnt_a, 9);
      check("sat_cnt_b", collision_cnt_b, 7);

      // Clear coincident with a colliding delivery.
      @(negedge CLK);
      in_valid = 1'b1; in_range_info = 16'h00AA;
      @(negedge CLK);
      in_valid = 1'b0; in_range_info = '0;
      @(negedge CLK);
      check("clr_valid", out_valid_a, 1);
      cnt_clear = 1'b1;
      @(negedge CLK);
      cnt_clear = 1'b0;
      check("clr_cnt",   collision_cnt_a, 0);
      check("clr_cnt_b", collision_cnt_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
